// File: rtl/program_loader_if.sv
// Byte stream in from the UART receiver, code RAM write port and loader status out.
// The loader is the slave; the byte source / system side is the master.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  code_we;
  logic [ADDR_WIDTH-1:0] code_waddr;
  logic [7:0]            code_wdata;
  logic                  core_hold;
  logic                  load_done;
  logic                  load_error;
  logic [1:0]            error_code;

  modport slave (
    input  rx_valid, rx_data,
    output code_we, code_waddr, code_wdata,
    output core_hold, load_done, load_error, error_code
  );

  modport master (
    output rx_valid, rx_data,
    input  code_we, code_waddr, code_wdata,
    input  core_hold, load_done, load_error, error_code
  );
endinterface

// File: rtl/program_loader.sv
// Framed program loader: sync, 16-bit LE length, payload, 8-bit additive checksum.
// Holds the core in reset until a frame has been written and verified.
module program_loader #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  program_loader_if.slave  bus
);
  localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;
  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_RUN
  } state_t;

  state_t                state;
  logic [7:0]            len_lo;
  logic [7:0]            sum;
  logic [15:0]           remain;
  logic [ADDR_WIDTH-1:0] addr;
  logic [TW-1:0]         idle_cnt;

  logic [15:0] len_full;
  logic        len_bad;
  logic        timed;

  assign len_full = {bus.rx_data, len_lo};
  assign len_bad  = (len_full == 16'd0) || (32'(len_full) > CAPACITY);
  assign timed    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      len_lo         <= '0;
      sum            <= '0;
      remain         <= '0;
      addr           <= '0;
      idle_cnt       <= '0;
      bus.code_we    <= 1'b0;
      bus.code_waddr <= '0;
      bus.code_wdata <= '0;
      bus.core_hold  <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
      bus.error_code <= 2'd0;
    end else begin
      bus.code_we   <= 1'b0;
      bus.load_done <= 1'b0;

      // Timeout counts silent cycles only; a byte on the limit edge wins.
      if (timed && !bus.rx_valid) begin
        if (idle_cnt == IDLE_LIMIT) begin
          idle_cnt       <= '0;
          state          <= S_IDLE;
          bus.load_error <= 1'b1;
          bus.error_code <= 2'd3;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      if (bus.rx_valid) begin
        case (state)
          S_IDLE, S_RUN: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state          <= S_LEN_LO;
              sum            <= '0;
              addr           <= '0;
              bus.core_hold  <= 1'b1;
              bus.load_error <= 1'b0;
              bus.error_code <= 2'd0;
            end
          end
          S_LEN_LO: begin
            len_lo <= bus.rx_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if (len_bad) begin
              state          <= S_IDLE;
              bus.load_error <= 1'b1;
              bus.error_code <= 2'd1;
            end else begin
              remain <= len_full;
              state  <= S_DATA;
            end
          end
          S_DATA: begin
            bus.code_we    <= 1'b1;
            bus.code_waddr <= addr;
            bus.code_wdata <= bus.rx_data;
            sum            <= sum + bus.rx_data;
            addr           <= addr + 1'b1;
            remain         <= remain - 1'b1;
            if (remain == 16'd1) state <= S_CHECK;
          end
          S_CHECK: begin
            if (bus.rx_data == sum) begin
              state         <= S_RUN;
              bus.load_done <= 1'b1;
              bus.core_hold <= 1'b0;
            end else begin
              state          <= S_IDLE;
              bus.load_error <= 1'b1;
              bus.error_code <= 2'd2;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte/response vector table plus
// hand sequences for timeout, 256-byte back-to-back frame and async reset.
module tb_program_loader;
  logic clk;
  logic rst_n;

  program_loader_if #(.ADDR_WIDTH(8)) bus ();

  program_loader #(
    .ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(100),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       done;
    logic       err;
    logic [1:0] code;
    logic       hold;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic av(input logic [7:0] d, input logic we, input logic [7:0] a,
                    input logic [7:0] wd, input logic dn, input logic er,
                    input logic [1:0] cd, input logic hd);
    vec_t v;
    v.data = d; v.we = we; v.addr = a; v.wdata = wd;
    v.done = dn; v.err = er; v.code = cd; v.hold = hd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {we, done, err, code, hold, addr, wdata}; address/data only meaningful with we
  function automatic logic [31:0] snap();
    return {10'd0, bus.code_we, bus.load_done, bus.load_error, bus.error_code,
            bus.core_hold,
            bus.code_we ? bus.code_waddr : 8'h00,
            bus.code_we ? bus.code_wdata : 8'h00};
  endfunction

  function automatic logic [31:0] pack(input vec_t v);
    return {10'd0, v.we, v.done, v.err, v.code, v.hold,
            v.we ? v.addr : 8'h00, v.we ? v.wdata : 8'h00};
  endfunction

  // Called at a negedge; the byte is sampled on the following posedge and
  // the response is visible at the negedge this task returns on.
  task automatic send_byte(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] d;

    // Good frame 11 22 33 44, sum AA
    av(8'hA5,0,0,0, 0,0,0,1); av(8'h04,0,0,0, 0,0,0,1); av(8'h00,0,0,0, 0,0,0,1);
    av(8'h11,1,0,8'h11, 0,0,0,1); av(8'h22,1,1,8'h22, 0,0,0,1);
    av(8'h33,1,2,8'h33, 0,0,0,1); av(8'h44,1,3,8'h44, 0,0,0,1);
    av(8'hAA,0,0,0, 1,0,0,0);
    // Reload from RUN, checksum mismatch (sum 03, sent FF)
    av(8'hA5,0,0,0, 0,0,0,1); av(8'h02,0,0,0, 0,0,0,1); av(8'h00,0,0,0, 0,0,0,1);
    av(8'h01,1,0,8'h01, 0,0,0,1); av(8'h02,1,1,8'h02, 0,0,0,1);
    av(8'hFF,0,0,0, 0,1,2,1);
    // Good frame clears the error
    av(8'hA5,0,0,0, 0,0,0,1); av(8'h01,0,0,0, 0,0,0,1); av(8'h00,0,0,0, 0,0,0,1);
    av(8'h7E,1,0,8'h7E, 0,0,0,1); av(8'h7E,0,0,0, 1,0,0,0);
    // Stray byte in RUN
    av(8'h00,0,0,0, 0,0,0,0);
    // Zero length
    av(8'hA5,0,0,0, 0,0,0,1); av(8'h00,0,0,0, 0,0,0,1); av(8'h00,0,0,0, 0,1,1,1);
    // Stray bytes in IDLE
    av(8'h00,0,0,0, 0,1,1,1); av(8'hFF,0,0,0, 0,1,1,1); av(8'h5A,0,0,0, 0,1,1,1);
    // Length 257 exceeds capacity
    av(8'hA5,0,0,0, 0,0,0,1); av(8'h01,0,0,0, 0,0,0,1); av(8'h01,0,0,0, 0,1,1,1);
    // One-byte good frame
    av(8'hA5,0,0,0, 0,0,0,1); av(8'h01,0,0,0, 0,0,0,1); av(8'h00,0,0,0, 0,0,0,1);
    av(8'h5A,1,0,8'h5A, 0,0,0,1); av(8'h5A,0,0,0, 1,0,0,0);

    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {10'd0, bus.code_we, bus.load_done, bus.load_error, bus.error_code,
         bus.core_hold, bus.code_waddr, bus.code_wdata},
        {10'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      send_byte(vecs[i].data);
      chk($sformatf("vec%0d", i), snap(), pack(vecs[i]));
    end

    // Timeout: 100 silent cycles after the last byte
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h11);
    repeat (99) @(negedge clk);
    chk("pre_timeout", {29'd0, bus.load_error, bus.error_code}, 32'd0);
    @(negedge clk);
    chk("timeout", {28'd0, bus.load_error, bus.error_code, bus.core_hold},
        {28'd0, 1'b1, 2'd3, 1'b1});
    send_byte(8'h04);
    chk("idle_after_timeout", {29'd0, bus.code_we, bus.error_code}, {29'd0, 1'b0, 2'd3});

    // Byte landing exactly on the timeout edge is accepted
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h11);
    repeat (99) @(negedge clk);
    send_byte(8'h22);
    chk("edge_byte", {13'd0, bus.code_we, bus.code_waddr, bus.code_wdata,
                      bus.load_error, bus.error_code},
        {13'd0, 1'b1, 8'd1, 8'h22, 1'b0, 2'd0});
    send_byte(8'h33); send_byte(8'h44); send_byte(8'hAA);
    chk("edge_frame_done", {29'd0, bus.load_done, bus.load_error, bus.core_hold},
        {29'd0, 1'b1, 1'b0, 1'b0});

    // Full-capacity frame, back-to-back bytes
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      d = 8'(i) ^ 8'h5C;
      s = s + d;
      bus.rx_valid = 1'b1;
      bus.rx_data  = d;
      @(negedge clk);
      chk($sformatf("full_b%0d", i),
          {14'd0, bus.code_we, bus.load_done, bus.core_hold, bus.code_waddr, bus.code_wdata},
          {14'd0, 1'b1, 1'b0, 1'b1, 8'(i), d});
    end
    bus.rx_data = s;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("full_done", {28'd0, bus.code_we, bus.load_done, bus.load_error, bus.core_hold},
        {28'd0, 1'b0, 1'b1, 1'b0, 1'b0});

    // Asynchronous reset mid-DATA
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1 chk("async_reset",
        {10'd0, bus.code_we, bus.load_done, bus.load_error, bus.error_code,
         bus.core_hold, bus.code_waddr, bus.code_wdata},
        {10'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00});
    @(negedge clk);
    send_byte(8'h33);
    chk("no_we_in_reset", {30'd0, bus.code_we, bus.core_hold}, {30'd0, 1'b0, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h44);
    chk("idle_after_reset", {30'd0, bus.code_we, bus.core_hold}, {30'd0, 1'b0, 1'b1});
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h42); send_byte(8'h42);
    chk("recover_frame", {30'd0, bus.load_done, bus.core_hold}, {30'd0, 1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Framed serial program loader that sits between the UART byte receiver and the byte-wide code RAM. It replaces free-running "write every received byte" loading with a checked protocol: sync byte, 16-bit length, payload and 8-bit checksum. It holds the processor core in reset until a frame is written and verified, and it reports framing, length, checksum and timeout errors.

## Interface
- ADDR_WIDTH, default 8: code RAM address width; capacity = 2^ADDR_WIDTH bytes.
- TIMEOUT_CYCLES, default 1_000_000: maximum number of idle cycles allowed between bytes inside a frame.
- SYNC_BYTE, default 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- code_we  out  1  code RAM byte write enable.
- code_waddr  out  ADDR_WIDTH  code RAM write address.
- code_wdata  out  8  code RAM write data.
- core_hold  out  1  high = core held in reset; drives the core reset OR-term.
- load_done  out  1  one-cycle pulse when a frame is accepted.
- load_error  out  1  sticky error flag.
- error_code  out  2  0 none, 1 bad length, 2 checksum mismatch, 3 timeout.

## Operation
- States:
  - IDLE: wait for a sync byte.
  - LEN_LO / LEN_HI: receive the 16-bit length, little-endian.
  - DATA: receive payload bytes.
  - CHECK: receive the checksum byte.
  - RUN: core released.
- IDLE:
  - rx_valid with rx_data == SYNC_BYTE → LEN_LO.
  - Accepting the sync byte clears load_error, sets error_code to 0, and zeroes the checksum accumulator and address counter.
  - Any other byte is ignored.
- LEN_LO captures the low length byte → LEN_HI.
- LEN_HI captures the high length byte:
  - If len == 0 or len > 2^ADDR_WIDTH: load_error = 1, error_code = 1 → IDLE.
  - Otherwise → DATA.
- DATA, on each byte:
  - code_we pulses with code_waddr = counter and code_wdata = byte.
  - sum <= sum + byte, mod 256.
  - counter increments.
  - After the len-th byte → CHECK.
  - code_waddr starts at 0 and never wraps within a frame, because length is bounded.
- CHECK:
  - Byte == sum: load_done pulses → RUN.
  - Mismatch: load_error = 1, error_code = 2 → IDLE.
- Timeout:
  - Applies in LEN_LO, LEN_HI, DATA and CHECK.
  - The idle counter resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES: load_error = 1, error_code = 3 → IDLE.
- RUN:
  - A sync byte reloads: core_hold rises, the loader goes to LEN_LO and errors are cleared.
  - Other bytes are ignored; the core keeps running.
- core_hold:
  - High in every state except RUN.
  - After an error, the core stays held until a good frame arrives.
- RAM contents written before a failed check are not rolled back; core_hold prevents their execution.

## Timing
- Reset (rst_n low, asynchronous):
  - State IDLE; core_hold = 1.
  - code_we = 0, code_waddr = 0, code_wdata = 0.
  - load_done = 0, load_error = 0, error_code = 0.
  - All counters and sum = 0.
- All outputs are registered.
- A response to rx_valid sampled at edge N is visible from edge N to edge N+1, and only there:
  - code_we is high for exactly that one cycle per payload byte.
  - code_waddr and code_wdata are stable during it.
- load_done is high for exactly one cycle. core_hold falls on the same edge that load_done rises.
- On a reload sync in RUN, core_hold rises on the edge that samples the sync byte.
- Timeout:
  - Fires on the edge where the idle counter equals TIMEOUT_CYCLES, counting cycles since the last accepted byte.
  - An rx_valid arriving on that same edge takes priority: the byte is processed and no timeout occurs.
- Back-to-back rx_valid on consecutive cycles must be accepted with no loss; there is no backpressure.
- rst_n asserted mid-frame aborts immediately. No further code_we occurs, and core_hold = 1.

## Test plan
- Reset then frame A5 04 00 11 22 33 44 AA:
  - Four code_we pulses at addresses 0–3 with data 11, 22, 33, 44.
  - load_done pulses once; core_hold falls; error_code = 0.
- Frame A5 02 00 01 02 FF:
  - error_code = 2, load_error = 1, core_hold stays 1.
  - A following good frame clears the error and releases the core.
- Frame A5 00 00 → error_code = 1 with no code_we. Frame A5 01 01 (len 257 > 256) → error_code = 1.
- Frame A5 04 00 11 followed by silence:
  - After TIMEOUT_CYCLES (bench sets 100), error_code = 3 and state is IDLE.
  - A byte arriving exactly at the timeout edge is accepted instead.
- Stray bytes 00 FF 5A in IDLE produce no writes. In RUN, byte 00 is ignored; byte A5 raises core_hold on the next edge and a new frame reloads.
- Full 256-byte frame driven with back-to-back rx_valid:
  - Addresses 0–255 written, no wrap.
  - Checksum verified, load_done pulses.
- Mid-DATA reset: rst_n pulled low asynchronously mid-frame; all outputs return to reset values immediately.
